// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master arbiter and related shared-bus logic.
package spi_pkg;
  localparam int DW_DEF      = 64;
  localparam int BW_DEF      = 3;
  localparam int TIMEOUT_DEF = 4095;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping modulo NREQ.
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   index,
  output logic            any
);
  int pos;

  // Walk from the farthest offset down so the nearest request to rr_ptr wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    pos    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        index       = IW'(pos);
        any         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master engine among NREQ requesters, one transaction per grant.
//   state   | meaning
//   IDLE    | arbitrate when a request is pending and the master is not busy
//   START   | winner latched; start pulse issued on the following cycle, timer cleared
//   WAIT    | count until master finished or timeout
//   RELEASE | done pulse to owner, advance round-robin pointer
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int DW      = DW_DEF,
  parameter int BW      = BW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*BW-1:0] req_bytes,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [DW-1:0]     rd_data,
  output logic              spi_start,
  output logic [DW-1:0]     spi_data,
  output logic [BW-1:0]     spi_bite_num,
  input  logic              spi_busy,
  input  logic              spi_finished,
  input  logic [DW-1:0]     spi_rd_data
);
  localparam int IW = idx_w(NREQ);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    rr_ptr, owner;
  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_index;
  logic             pick_any;
  logic             arb;
  logic [DW-1:0]    sel_data;
  logic [BW-1:0]    sel_bytes;

  spi_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  assign sel_data  = req_data[pick_index*DW +: DW];
  assign sel_bytes = req_bytes[pick_index*BW +: BW];
  assign arb       = (state == ST_IDLE) && pick_any && !spi_busy;
  assign done      = (state == ST_RELEASE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arb) state_nxt = (sel_bytes != '0) ? ST_START : ST_RELEASE;
      ST_START:   state_nxt = ST_WAIT;
      ST_WAIT:    if (spi_finished || cnt == TO_LAST) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Start is registered so it lands one cycle after grant, aligned with the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      rd_data      <= '0;
      spi_start    <= 1'b0;
      spi_data     <= '0;
      spi_bite_num <= '0;
    end else begin
      spi_start <= (state == ST_START);
      case (state)
        ST_IDLE: begin
          if (arb) begin
            grant        <= pick_onehot;
            owner        <= pick_index;
            spi_data     <= sel_data;
            spi_bite_num <= sel_bytes;
            if (sel_bytes == '0) err <= 1'b1;
          end
        end
        ST_START: cnt <= '0;
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (spi_finished) begin
            rd_data <= spi_rd_data;
            err     <= 1'b0;
          end else if (cnt == TO_LAST) begin
            err <= 1'b1;
          end
        end
        ST_RELEASE: begin
          grant  <= '0;
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed + randomized bench for spi_master_arbiter against a transaction-level reference model.
module tb_spi_master_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 64;
  localparam int BW   = 3;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*BW-1:0] req_bytes;
  logic [NREQ-1:0]   grant, done;
  logic              err, spi_start;
  logic [DW-1:0]     rd_data, spi_data, spi_rd_data;
  logic [BW-1:0]     spi_bite_num;
  logic              spi_busy, spi_finished;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr;
  logic [DW-1:0] m_rd;

  always #5 clk = ~clk;

  spi_master_arbiter #(.NREQ(NREQ), .DW(DW), .BW(BW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .req_bytes    (req_bytes),
    .grant        (grant),
    .done         (done),
    .err          (err),
    .rd_data      (rd_data),
    .spi_start    (spi_start),
    .spi_data     (spi_data),
    .spi_bite_num (spi_bite_num),
    .spi_busy     (spi_busy),
    .spi_finished (spi_finished),
    .spi_rd_data  (spi_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic int pick(input logic [NREQ-1:0] rv, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (rv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  task automatic rand_inputs;
    for (int i = 0; i < NREQ * DW / 32; i++) req_data[i*32 +: 32] = $urandom;
    req_bytes = (NREQ*BW)'($urandom);
  endtask

  // One full transaction; fin_d < 0 means the master never finishes.
  task automatic run_txn(input logic [NREQ-1:0] rv, input bit hold, input int fin_d);
    int w;
    logic [NREQ-1:0] oh;
    logic [DW-1:0] ed, rd;
    logic [BW-1:0] eb;
    spi_busy = 1'b0;
    req = rv;
    w  = pick(rv, m_ptr);
    oh = '0;
    oh[w] = 1'b1;
    ed = req_data[w*DW +: DW];
    eb = req_bytes[w*BW +: BW];
    tick;
    chk("grant", grant, oh);
    chk("spi_data", spi_data, ed);
    chk("bite_num", spi_bite_num, eb);
    if (!hold) req = '0;
    rand_inputs;
    if (eb == '0) begin
      chk("start_zero", spi_start, 0);
      chk("done_zero", done, oh);
      chk("err_zero", err, 1);
    end else begin
      chk("start_early", spi_start, 0);
      chk("done_early", done, 0);
      tick;
      chk("spi_start", spi_start, 1);
      chk("spi_data_hold", spi_data, ed);
      chk("bite_hold", spi_bite_num, eb);
      if (fin_d >= 0) begin
        repeat (fin_d) begin
          tick;
          chk("done_wait", done, 0);
        end
        rd = {$urandom, $urandom};
        spi_rd_data  = rd;
        spi_finished = 1'b1;
        tick;
        spi_finished = 1'b0;
        m_rd = rd;
        chk("done", done, oh);
        chk("grant_own", grant, oh);
        chk("err", err, 0);
        chk("rd_data", rd_data, m_rd);
      end else begin
        repeat (TO - 1) tick;
        chk("done_before_to", done, 0);
        tick;
        chk("done_to", done, oh);
        chk("err_to", err, 1);
        chk("rd_hold", rd_data, m_rd);
      end
    end
    m_ptr = (w + 1) % NREQ;
    tick;
    chk("grant_rel", grant, 0);
    chk("done_rel", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0; req_data = '0; req_bytes = '0;
    spi_busy = 1'b0; spi_finished = 1'b0; spi_rd_data = '0;
    m_ptr = 0; m_rd = '0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_data", spi_data, 0);
    chk("rst_bytes", spi_bite_num, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // Single request with a known frame.
    rand_inputs;
    req_data[0 +: DW] = 64'h05A2;
    req_bytes[0 +: BW] = 3'd2;
    run_txn(3'b001, 1'b0, 3);

    // Fairness with all requesters held.
    for (int i = 0; i < 4; i++) begin
      rand_inputs;
      for (int j = 0; j < NREQ; j++) req_bytes[j*BW +: BW] = 3'd1 + BW'($urandom_range(0, 6));
      run_txn(3'b111, (i < 3), 9);
    end

    // Busy gating.
    rand_inputs;
    req_bytes[1*BW +: BW] = 3'd4;
    spi_busy = 1'b1;
    req = 3'b010;
    repeat (3) begin
      tick;
      chk("busy_gate", grant, 0);
    end
    run_txn(3'b010, 1'b0, 2);

    // Timeout, then a normal transaction.
    rand_inputs;
    req_bytes[0 +: BW] = 3'd3;
    run_txn(3'b001, 1'b0, -1);
    rand_inputs;
    req_bytes[1*BW +: BW] = 3'd5;
    run_txn(3'b010, 1'b0, 1);

    // Zero byte count, then pointer check.
    rand_inputs;
    req_bytes[2*BW +: BW] = 3'd0;
    run_txn(3'b100, 1'b0, 0);
    rand_inputs;
    for (int j = 0; j < NREQ; j++) req_bytes[j*BW +: BW] = 3'd2;
    run_txn(3'b111, 1'b0, 0);

    // Finished on the timeout cycle wins.
    rand_inputs;
    req_bytes[2*BW +: BW] = 3'd7;
    run_txn(3'b100, 1'b0, TO - 1);

    // Spurious finished in IDLE.
    spi_rd_data  = {$urandom, $urandom};
    spi_finished = 1'b1;
    tick;
    spi_finished = 1'b0;
    chk("spur_done", done, 0);
    chk("spur_grant", grant, 0);
    chk("spur_rd", rd_data, m_rd);
    tick;
    chk("spur_grant2", grant, 0);

    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      rand_inputs;
      run_txn(NREQ'($urandom_range(1, 7)), 1'b0,
              ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1)));
    end

    // Async reset in WAIT.
    rand_inputs;
    req_bytes[1*BW +: BW] = 3'd6;
    req = 3'b010;
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_done", done, 0);
    chk("arst_start", spi_start, 0);
    chk("arst_data", spi_data, 0);
    chk("arst_rd", rd_data, 0);
    chk("arst_err", err, 0);
    req = '0;
    tick;
    rst_n = 1'b1;
    m_ptr = 0; m_rd = '0;
    tick;
    chk("arst_idle", grant, 0);
    rand_inputs;
    run_txn(3'b110, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
